// File: rtl/mdu_arbiter.sv
// mdu_arbiter: round-robin sharing of one multicycle multiply/divide unit
// (HI/LO holder) between two requesters. One transaction at a time; the MDU
// sees OP_NOP with zero operands in every cycle except the single issue cycle.
module mdu_arbiter (
    input  logic        clk,
    input  logic        reset,
    // requester 0
    input  logic        i_r0_valid,
    input  logic [3:0]  i_r0_op,
    input  logic [31:0] i_r0_a,
    input  logic [31:0] i_r0_b,
    output logic        o_r0_ready,
    output logic        o_r0_rvalid,
    output logic [31:0] o_r0_rdata,
    // requester 1
    input  logic        i_r1_valid,
    input  logic [3:0]  i_r1_op,
    input  logic [31:0] i_r1_a,
    input  logic [31:0] i_r1_b,
    output logic        o_r1_ready,
    output logic        o_r1_rvalid,
    output logic [31:0] o_r1_rdata,
    // multiply/divide unit
    output logic        o_mdu_start,
    output logic [3:0]  o_mdu_op,
    output logic [31:0] o_mdu_a,
    output logic [31:0] o_mdu_b,
    input  logic [31:0] i_mdu_do,
    input  logic        i_mdu_busy,
    // status
    output logic        o_arb_busy,
    output logic        o_owner
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
    localparam logic [OP_W-1:0] OP_MFLO  = 4'd6;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Ops that start a timed operation in the MDU
    function automatic logic f_is_muldiv(input logic [OP_W-1:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: f_is_muldiv = 1'b1;
            default:                            f_is_muldiv = 1'b0;
        endcase
    endfunction

    // Ops the MDU understands; anything else is issued as OP_NOP
    function automatic logic f_is_known(input logic [OP_W-1:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: f_is_known = 1'b1;
            default:                           f_is_known = 1'b0;
        endcase
    endfunction

    state_t             r_state;
    logic               r_last_grant;
    logic [OP_W-1:0]    r_op_q;

    logic               w_accept;
    logic               w_winner;
    logic [OP_W-1:0]    w_win_op;
    logic [DATA_W-1:0]  w_win_a;
    logic [DATA_W-1:0]  w_win_b;
    logic               w_to_done;
    logic [DATA_W-1:0]  w_done_data;

    // Arbitration: single valid wins outright, a tie goes to the requester not granted last
    always_comb begin
        w_winner = 1'b0;
        if (i_r0_valid && i_r1_valid) begin
            w_winner = ~r_last_grant;
        end else if (i_r1_valid) begin
            w_winner = 1'b1;
        end
        w_accept = !reset && (r_state == S_IDLE) && !i_mdu_busy
                   && (i_r0_valid || i_r1_valid);
        w_win_op = w_winner ? i_r1_op : i_r0_op;
        w_win_a  = w_winner ? i_r1_a  : i_r0_a;
        w_win_b  = w_winner ? i_r1_b  : i_r0_b;
    end

    assign o_r0_ready = w_accept && !w_winner;
    assign o_r1_ready = w_accept &&  w_winner;

    // Completion detect and the data returned to the owner in the DONE cycle
    always_comb begin
        w_to_done   = 1'b0;
        w_done_data = '0;
        if (r_state == S_ISSUE) begin
            w_to_done = !f_is_muldiv(r_op_q);
            if ((r_op_q == OP_MFHI) || (r_op_q == OP_MFLO)) begin
                w_done_data = i_mdu_do;
            end
        end else if (r_state == S_WAIT) begin
            w_to_done = !i_mdu_busy;
        end
    end

    // Transaction FSM with registered MDU drive and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_op_q       <= OP_NOP;
            o_owner      <= 1'b0;
            o_arb_busy   <= 1'b0;
            o_r0_rvalid  <= 1'b0;
            o_r1_rvalid  <= 1'b0;
            o_r0_rdata   <= '0;
            o_r1_rdata   <= '0;
            o_mdu_start  <= 1'b0;
            o_mdu_op     <= OP_NOP;
            o_mdu_a      <= '0;
            o_mdu_b      <= '0;
        end else begin
            o_mdu_start <= 1'b0;
            o_mdu_op    <= OP_NOP;
            o_mdu_a     <= '0;
            o_mdu_b     <= '0;
            o_r0_rvalid <= 1'b0;
            o_r1_rvalid <= 1'b0;

            if (w_to_done) begin
                if (o_owner) begin
                    o_r1_rvalid <= 1'b1;
                    o_r1_rdata  <= w_done_data;
                end else begin
                    o_r0_rvalid <= 1'b1;
                    o_r0_rdata  <= w_done_data;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_q       <= w_win_op;
                        o_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        o_mdu_op     <= f_is_known(w_win_op) ? w_win_op : OP_NOP;
                        o_mdu_start  <= f_is_muldiv(w_win_op);
                        o_mdu_a      <= w_win_a;
                        o_mdu_b      <= w_win_b;
                        o_arb_busy   <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= f_is_muldiv(r_op_q) ? S_WAIT : S_DONE;
                end
                S_WAIT: begin
                    if (!i_mdu_busy) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_arb_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_arbiter.sv
// Testbench for mdu_arbiter: behavioural MDU (5-cycle mult, 10-cycle div),
// directed requests, and a scoreboard of expected responses with due cycles.
module tb_mdu_arbiter;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r1_valid;
    logic [3:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mdu_start, mdu_busy, arb_busy, owner;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_a, mdu_b, mdu_do;

    always #5 clk = ~clk;

    mdu_arbiter dut (
        .clk(clk), .reset(reset),
        .i_r0_valid(r0_valid), .i_r0_op(r0_op), .i_r0_a(r0_a), .i_r0_b(r0_b),
        .o_r0_ready(r0_ready), .o_r0_rvalid(r0_rvalid), .o_r0_rdata(r0_rdata),
        .i_r1_valid(r1_valid), .i_r1_op(r1_op), .i_r1_a(r1_a), .i_r1_b(r1_b),
        .o_r1_ready(r1_ready), .o_r1_rvalid(r1_rvalid), .o_r1_rdata(r1_rdata),
        .o_mdu_start(mdu_start), .o_mdu_op(mdu_op), .o_mdu_a(mdu_a), .o_mdu_b(mdu_b),
        .i_mdu_do(mdu_do), .i_mdu_busy(mdu_busy),
        .o_arb_busy(arb_busy), .o_owner(owner)
    );

    // ---------------- behavioural MDU ----------------
    logic [31:0] m_hi, m_lo;
    logic [3:0]  m_timer;

    function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        mdu_calc = 64'd0;
        case (op)
            OP_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                mdu_calc = 64'(sp);
            end
            OP_MULTU: mdu_calc = {32'd0, a} * {32'd0, b};
            OP_DIV:   if (b != 32'd0) mdu_calc = {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  if (b != 32'd0) mdu_calc = {a % b, a / b};
            default:  mdu_calc = 64'd0;
        endcase
    endfunction

    assign mdu_busy = (m_timer != 4'd0);
    assign mdu_do   = (mdu_op == OP_MFHI) ? m_hi : (mdu_op == OP_MFLO) ? m_lo : 32'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_timer <= 4'd0;
        end else begin
            if (m_timer != 4'd0) m_timer <= m_timer - 4'd1;
            if (mdu_start) begin
                {m_hi, m_lo} <= mdu_calc(mdu_op, mdu_a, mdu_b);
                m_timer <= ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU)) ? 4'd5 : 4'd10;
            end
            if (mdu_op == OP_MTHI) m_hi <= mdu_a;
            if (mdu_op == OP_MTLO) m_lo <= mdu_a;
        end
    end

    // ---------------- scoreboard and checking ----------------
    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        prev_acc = 1'b0;
    logic        acc0, acc1;
    logic        exp_start;
    logic [3:0]  exp_op;
    logic [31:0] exp_a;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic f_muldiv(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic f_known(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Per-cycle checks, sampled 1 time unit after the negedge drive point
    task automatic observe();
        exp_t e;
        logic [3:0] wop;
        #1;
        if (prev_acc) begin
            chk("issue_start", 32'(mdu_start), 32'(exp_start));
            chk("issue_op",    32'(mdu_op),    32'(exp_op));
            chk("issue_a",     mdu_a,          exp_a);
        end else begin
            chk("idle_start_op", {27'd0, mdu_start, mdu_op}, 32'd0);
            chk("idle_ab",       mdu_a | mdu_b,              32'd0);
        end
        if (r0_rvalid || r1_rvalid) begin
            if (sb.size() == 0) begin
                chk("spurious_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rvalid_port",  32'({r1_rvalid, r0_rvalid}), (e.port == 1) ? 32'd2 : 32'd1);
                chk("rvalid_cycle", 32'(cyc), 32'(e.due));
                chk("rdata",        (e.port == 1) ? r1_rdata : r0_rdata, e.data);
                chk("owner",        32'(owner), 32'(e.port));
            end
        end
        if (sb.size() != 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            chk("rvalid_missing", 32'((e.port == 1) ? r1_rvalid : r0_rvalid), 32'd1);
        end
        acc0 = r0_ready;
        acc1 = r1_ready;
        if (acc0 || acc1) begin
            wop       = acc1 ? r1_op : r0_op;
            exp_op    = f_known(wop) ? wop : OP_NOP;
            exp_start = f_muldiv(wop);
            exp_a     = acc1 ? r1_a : r0_a;
        end
        prev_acc = (acc0 || acc1) && !reset;
    endtask

    task automatic set_req(input int port, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin r0_valid = v; r0_op = op; r0_a = a; r0_b = b; end
        else           begin r1_valid = v; r1_op = op; r1_a = a; r1_b = b; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            observe();
        end
    endtask

    // Issue one request, expect its response lat cycles after accept
    task automatic do_req(input int port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] data, input int lat);
        bit got;
        got = 1'b0;
        @(negedge clk);
        set_req(port, 1'b1, op, a, b);
        for (int i = 0; i < 30 && !got; i++) begin
            if (i > 0) @(negedge clk);
            observe();
            if ((port == 0 && acc0) || (port == 1 && acc1)) begin
                got = 1'b1;
                sb.push_back('{port, data, cyc + lat});
            end
        end
        if (!got) chk("ready_timeout", 32'((port == 0) ? r0_ready : r1_ready), 32'd1);
        @(negedge clk);
        set_req(port, 1'b0, OP_NOP, 32'd0, 32'd0);
        observe();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            observe();
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 1'b0, OP_NOP, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_NOP, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        prev_acc = 1'b0;
        sb.delete();
    endtask

    initial begin
        int ng;
        int last_t;
        bit got;
        reset = 1'b1;
        set_req(0, 1'b0, OP_NOP, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_NOP, 32'd0, 32'd0);
        apply_reset();

        // reset state
        #1;
        chk("rst_ready",  32'({r1_ready, r0_ready}),   32'd0);
        chk("rst_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
        chk("rst_busy",   32'(arb_busy),               32'd0);
        chk("rst_owner",  32'(owner),                  32'd0);
        chk("rst_rdata0", r0_rdata,                    32'd0);
        chk("rst_rdata1", r1_rdata,                    32'd0);
        chk("rst_mdu",    {27'd0, mdu_start, mdu_op},  32'd0);
        chk("rst_mdu_ab", mdu_a | mdu_b,               32'd0);

        // signed multiply and reads
        do_req(0, OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 8);
        do_req(0, OP_MFLO, 32'd0, 32'd0, 32'hFFFF_FFFA, 2);
        idle(2);
        chk("rdata_hold", r0_rdata, 32'hFFFF_FFFA);
        do_req(0, OP_MFHI, 32'd0, 32'd0, 32'hFFFF_FFFF, 2);

        // signed divide and reads
        do_req(1, OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'd0, 13);
        do_req(1, OP_MFLO, 32'd0, 32'd0, 32'hFFFF_FFFD, 2);
        do_req(1, OP_MFHI, 32'd0, 32'd0, 32'h0000_0001, 2);

        // HI written by r0 is visible to r1
        do_req(0, OP_MTHI, 32'h1234_5678, 32'd0, 32'd0, 2);
        do_req(1, OP_MFHI, 32'd0, 32'd0, 32'h1234_5678, 2);

        // both requesters held valid from reset: strict alternation starting at r0
        apply_reset();
        set_req(0, 1'b1, OP_MULTU, 32'd2, 32'd3);
        set_req(1, 1'b1, OP_MULTU, 32'd4, 32'd5);
        ng = 0;
        last_t = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            if (i > 0) @(negedge clk);
            observe();
            if (acc0 || acc1) begin
                chk("grant_order", 32'({acc1, acc0}), (ng % 2 == 0) ? 32'd1 : 32'd2);
                if (ng > 0) chk("grant_gap", 32'(cyc - last_t), 32'd9);
                last_t = cyc;
                sb.push_back('{acc1 ? 1 : 0, 32'd0, cyc + 8});
                ng++;
            end
        end
        chk("grant_count", 32'(ng), 32'd4);
        @(negedge clk);
        set_req(0, 1'b0, OP_NOP, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_NOP, 32'd0, 32'd0);
        observe();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            observe();
        end

        // reset in the third WAIT cycle of a divide aborts it silently
        got = 1'b0;
        @(negedge clk);
        set_req(1, 1'b1, OP_DIV, 32'd7, 32'd2);
        for (int i = 0; i < 20 && !got; i++) begin
            if (i > 0) @(negedge clk);
            observe();
            got = acc1;
        end
        chk("abort_accept", 32'(got), 32'd1);
        @(negedge clk);
        set_req(1, 1'b0, OP_NOP, 32'd0, 32'd0);
        observe();
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        observe();
        @(negedge clk);
        reset = 1'b0;
        observe();
        chk("abort_idle", 32'(arb_busy), 32'd0);
        chk("abort_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
        idle(14);
        do_req(0, OP_MFLO, 32'd0, 32'd0, 32'd0, 2);

        // unknown op: no MDU effect, zero data
        do_req(0, OP_MTLO, 32'hA5A5_A5A5, 32'd0, 32'd0, 2);
        do_req(1, 4'd12, 32'hDEAD_BEEF, 32'd1, 32'd0, 2);
        do_req(0, OP_MFLO, 32'd0, 32'd0, 32'hA5A5_A5A5, 2);
        do_req(0, OP_MFHI, 32'd0, 32'd0, 32'd0, 2);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
